rv32v_mem_lane_sequencer: RTL and testbench
===========================================

Name: rv32v_mem_lane_sequencer

Overview:
Vector memory-stage controller between the execute/memory pipeline register and the single data-memory port. It accepts a two-lane vector load/store request and serialises lane 0 then lane 1 onto the port. It generates element byte enables and lane-placed store data, extracts and zero-extends load data, and stalls upstream until the request completes. Lanes are enabled by the 2-bit write-enable mask.

Parameters:
- ADDR_W, 32, address width of aluresult0/1 and dmem_addr.
- DATA_W, 32, word width; fixed at 32, other values unsupported.

Ports:
- CLK  in  1  clock; one clock domain.
- nRST  in  1  asynchronous, active-low reset.
- load_ena  in  1  vector load request.
- store_ena  in  1  vector store request.
- wen  in  2  lane mask; bit i enables lane i.
- eew  in  2  element width: 0=8b, 1=16b, 2=32b, 3=reserved.
- aluresult0  in  ADDR_W  lane-0 byte address.
- aluresult1  in  ADDR_W  lane-1 byte address.
- storedata0  in  32  lane-0 store element, right-justified.
- storedata1  in  32  lane-1 store element, right-justified.
- stall  out  1  upstream must hold its inputs.
- done  out  1  one-cycle completion pulse.
- loaddata0  out  32  lane-0 load result, zero-extended.
- loaddata1  out  32  lane-1 load result, zero-extended.
- lane_err  out  2  per-lane misalignment or reserved-eew flag.
- dmem_ren  out  1  port read request.
- dmem_wen  out  1  port write request.
- dmem_addr  out  ADDR_W  word-aligned address.
- dmem_wdata  out  32  store word.
- dmem_byte_en  out  4  byte strobes.
- dmem_rdata  in  32  read word; valid with dmem_ack.
- dmem_ack  in  1  port accepts or completes the current request.

Behaviour:
- Clock and reset: single clock CLK; asynchronous active-low reset nRST.
- Reset values: state IDLE; all outputs 0, including loaddata0/1, lane_err and the dmem_* ports.
- FSM states: IDLE, LANE0, LANE1, DONE.
- Accept: in IDLE when (load_ena|store_ena) && wen!=0. Latch op, wen, eew, both addresses and both store data.
  - If store_ena and load_ena are both high, it is a store.
  - If wen==0, nothing is accepted.
- stall = (IDLE && accept) | LANE0 | LANE1. stall is 0 in DONE, so upstream advances on the done edge. Inputs are ignored outside IDLE.
- Transitions:
  - IDLE -> LANE0 if wen[0], else LANE1.
  - LANE0 on ack or lane skip -> LANE1 if wen[1], else DONE.
  - LANE1 on ack or lane skip -> DONE.
  - DONE -> IDLE unconditionally; done=1 for exactly that cycle.
- Lane access:
  - dmem_ren or dmem_wen (per op) is combinationally high in an enabled lane state.
  - dmem_addr = {addr[ADDR_W-1:2],2'b00}.
  - All dmem_* outputs are held stable until dmem_ack. dmem_ack is ignored when no request is active.
- Alignment:
  - eew=0: any offset.
  - eew=1: addr[0]==0.
  - eew=2: addr[1:0]==0.
  - eew=3, or a violation: set lane_err[i], issue no port request, advance next cycle.
- Byte enables: eew0 4'b0001<<addr[1:0]; eew1 4'b0011<<addr[1:0]; eew2 4'b1111.
- Store data: eew0 {4{d[7:0]}}; eew1 {2{d[15:0]}}; eew2 d.
- Load data: on ack, capture the selected byte/halfword/word of dmem_rdata at addr[1:0], zero-extend, and register into loaddataN.
- Output hold: loaddata and lane_err are cleared on accept and held from DONE until the next accept. loaddata stays 0 for stores, disabled lanes and error lanes.
- Latency, zero wait states: two lanes gives done 3 cycles after the accept cycle; one lane gives 2. Each wait cycle adds 1.
- Reset mid-operation: returns to IDLE immediately and drops any dmem request. No partial done is issued.

Optional Feature:
- Macro: RV32V_MEM_SEQ_PERF_EN.
- When defined: 32-bit outputs perf_access_cnt and perf_stall_cnt are added.
  - perf_access_cnt increments on each dmem_ack taken.
  - perf_stall_cnt increments on each cycle stall=1.
  - Both wrap modulo 2^32 and reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load, wen=2'b11, eew=2, aluresult0=0x100, aluresult1=0x104, ack tied 1, rdata=0xDEADBEEF then 0x12345678 -> reads at 0x100 and 0x104, byte_en 4'hF; done at accept+3 with loaddata0=0xDEADBEEF, loaddata1=0x12345678, lane_err=0.
- Store, wen=2'b10, eew=0, aluresult1=0x203, storedata1=0x000000AB -> single write at 0x200, byte_en 4'b1000, wdata 0xABABABAB; done at accept+2.
- Load, wen=2'b01, eew=1, addr=0x102, ack delayed 3 cycles, rdata=0xCAFE0000 -> dmem_addr=0x100, byte_en 4'b1100 held 4 cycles, stall held; loaddata0=0x0000CAFE.
- Load, wen=2'b11, eew=1, aluresult0=0x101, aluresult1=0x104 -> one read only (0x104), lane_err=2'b01, loaddata0=0.
- nRST low during LANE1 wait -> all outputs 0 immediately; after release, a new request is accepted and completes normally.
- load_ena=1 with wen=2'b00 -> stall=0, done never pulses, no port activity. With RV32V_MEM_SEQ_PERF_EN, test 1 yields perf_access_cnt=2 and perf_stall_cnt=3.

Source files
------------

// File: rtl/rv32v_mem_lane_sequencer.sv
// Two-lane vector load/store sequencer: serialises lane 0 then lane 1 onto one data-memory port.
// Optional performance counters are enabled by defining RV32V_MEM_SEQ_PERF_EN.
module rv32v_mem_lane_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load_ena,
  input  logic              store_ena,
  input  logic [1:0]        wen,
  input  logic [1:0]        eew,
  input  logic [ADDR_W-1:0] aluresult0,
  input  logic [ADDR_W-1:0] aluresult1,
  input  logic [DATA_W-1:0] storedata0,
  input  logic [DATA_W-1:0] storedata1,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] loaddata0,
  output logic [DATA_W-1:0] loaddata1,
  output logic [1:0]        lane_err,
  output logic              dmem_ren,
  output logic              dmem_wen,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_byte_en,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack
`ifdef RV32V_MEM_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_access_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LANE0, S_LANE1, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                r_store;
  logic [1:0]          r_wen, r_eew;
  logic [ADDR_W-1:0]   r_addr0, r_addr1;
  logic [DATA_W-1:0]   r_sdata0, r_sdata1;

  logic                w_accept, w_lane1, w_in_lane, w_err, w_req, w_adv, w_take;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_sdata, w_rshift, w_ldval;
  logic [1:0]          w_off;

  assign w_accept  = (r_state == S_IDLE) && (load_ena || store_ena) && (wen != 2'b00);
  assign w_lane1   = (r_state == S_LANE1);
  assign w_in_lane = (r_state == S_LANE0) || w_lane1;
  assign w_addr    = w_lane1 ? r_addr1 : r_addr0;
  assign w_sdata   = w_lane1 ? r_sdata1 : r_sdata0;
  assign w_off     = w_addr[1:0];

  always_comb begin
    unique case (r_eew)
      2'd0:    w_err = 1'b0;
      2'd1:    w_err = w_off[0];
      2'd2:    w_err = |w_off;
      default: w_err = 1'b1;
    endcase
  end

  // An erroring lane issues no port request and is skipped on the next edge.
  assign w_req  = w_in_lane && !w_err;
  assign w_adv  = w_in_lane && (w_err || dmem_ack);
  assign w_take = w_req && dmem_ack;

  assign w_rshift = dmem_rdata >> {w_off, 3'b000};
  always_comb begin
    unique case (r_eew)
      2'd0:    w_ldval = {{(DATA_W-8){1'b0}}, w_rshift[7:0]};
      2'd1:    w_ldval = {{(DATA_W-16){1'b0}}, w_rshift[15:0]};
      default: w_ldval = dmem_rdata;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    stall        = 1'b0;
    done         = 1'b0;
    dmem_ren     = 1'b0;
    dmem_wen     = 1'b0;
    dmem_addr    = '0;
    dmem_wdata   = '0;
    dmem_byte_en = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          stall  = 1'b1;
          w_next = wen[0] ? S_LANE0 : S_LANE1;
        end
      end
      S_LANE0: begin
        stall = 1'b1;
        if (w_adv) w_next = r_wen[1] ? S_LANE1 : S_DONE;
      end
      S_LANE1: begin
        stall = 1'b1;
        if (w_adv) w_next = S_DONE;
      end
      default: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
    endcase
    if (w_req) begin
      dmem_ren  = !r_store;
      dmem_wen  = r_store;
      dmem_addr = {w_addr[ADDR_W-1:2], 2'b00};
      unique case (r_eew)
        2'd0: begin
          dmem_byte_en = 4'b0001 << w_off;
          dmem_wdata   = {4{w_sdata[7:0]}};
        end
        2'd1: begin
          dmem_byte_en = 4'b0011 << w_off;
          dmem_wdata   = {2{w_sdata[15:0]}};
        end
        default: begin
          dmem_byte_en = 4'b1111;
          dmem_wdata   = w_sdata;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_IDLE;
      r_store   <= 1'b0;
      r_wen     <= '0;
      r_eew     <= '0;
      r_addr0   <= '0;
      r_addr1   <= '0;
      r_sdata0  <= '0;
      r_sdata1  <= '0;
      loaddata0 <= '0;
      loaddata1 <= '0;
      lane_err  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_store   <= store_ena;
        r_wen     <= wen;
        r_eew     <= eew;
        r_addr0   <= aluresult0;
        r_addr1   <= aluresult1;
        r_sdata0  <= storedata0;
        r_sdata1  <= storedata1;
        loaddata0 <= '0;
        loaddata1 <= '0;
        lane_err  <= '0;
      end
      if (w_in_lane && w_err) begin
        if (w_lane1) lane_err[1] <= 1'b1;
        else         lane_err[0] <= 1'b1;
      end
      if (w_take && !r_store) begin
        if (w_lane1) loaddata1 <= w_ldval;
        else         loaddata0 <= w_ldval;
      end
    end
  end

`ifdef RV32V_MEM_SEQ_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_access_cnt <= '0;
      perf_stall_cnt  <= '0;
    end else begin
      if (w_take) perf_access_cnt <= perf_access_cnt + 32'd1;
      if (stall)  perf_stall_cnt  <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32v_mem_lane_sequencer.sv
// Directed bench for rv32v_mem_lane_sequencer: scoreboarded port transactions and lane results.
module tb_rv32v_mem_lane_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        load_ena, store_ena;
  logic [1:0]  wen, eew;
  logic [31:0] aluresult0, aluresult1, storedata0, storedata1;
  logic        stall, done;
  logic [31:0] loaddata0, loaddata1;
  logic [1:0]  lane_err;
  logic        dmem_ren, dmem_wen;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_byte_en;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  rv32v_mem_lane_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .load_ena(load_ena), .store_ena(store_ena),
    .wen(wen), .eew(eew), .aluresult0(aluresult0), .aluresult1(aluresult1),
    .storedata0(storedata0), .storedata1(storedata1), .stall(stall), .done(done),
    .loaddata0(loaddata0), .loaddata1(loaddata1), .lane_err(lane_err),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdata;
    int unsigned wait_cyc;
  } port_t;

  typedef struct {
    logic [31:0] ld0;
    logic [31:0] ld1;
    logic [1:0]  err;
  } res_t;

  port_t exp_port[$];
  res_t  exp_res[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned wcnt     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Memory model: answers the oldest expected transaction after its wait count.
  always @(negedge CLK) begin
    if (nRST && (dmem_ren || dmem_wen)) begin
      if (exp_port.size() == 0) begin
        check("unexpected_port_req", {31'b0, dmem_ren | dmem_wen}, 32'd0);
        dmem_ack = 1'b0;
      end else begin
        check("port_addr", dmem_addr, exp_port[0].addr);
        check("port_be", {28'b0, dmem_byte_en}, {28'b0, exp_port[0].be});
        check("port_wen", {31'b0, dmem_wen}, {31'b0, exp_port[0].wr});
        check("port_ren", {31'b0, dmem_ren}, {31'b0, !exp_port[0].wr});
        if (exp_port[0].wr) check("port_wdata", dmem_wdata, exp_port[0].wdata);
        if (wcnt >= exp_port[0].wait_cyc) begin
          dmem_ack   = 1'b1;
          dmem_rdata = exp_port[0].rdata;
          void'(exp_port.pop_front());
          wcnt = 0;
        end else begin
          dmem_ack = 1'b0;
          wcnt++;
        end
      end
    end else begin
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      wcnt       = 0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input logic ld, input logic st, input logic [1:0] w, input logic [1:0] e,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] s0, input logic [31:0] s1, input int unsigned lat);
    int unsigned k;
    res_t r;
    load_ena = ld; store_ena = st; wen = w; eew = e;
    aluresult0 = a0; aluresult1 = a1; storedata0 = s0; storedata1 = s1;
    #1;
    check("stall_on_accept", {31'b0, stall}, 32'd1);
    tick();
    load_ena = 1'b0; store_ena = 1'b0;
    wen = 2'($urandom); eew = 2'($urandom);
    aluresult0 = $urandom; aluresult1 = $urandom; storedata0 = $urandom; storedata1 = $urandom;
    k = 1;
    while (!done && k < 40) begin
      check("stall_busy", {31'b0, stall}, 32'd1);
      tick();
      k++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    check("latency", k, lat);
    check("stall_in_done", {31'b0, stall}, 32'd0);
    r = exp_res.pop_front();
    check("loaddata0", loaddata0, r.ld0);
    check("loaddata1", loaddata1, r.ld1);
    check("lane_err", {30'b0, lane_err}, {30'b0, r.err});
    tick();
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("hold_loaddata0", loaddata0, r.ld0);
    check("hold_loaddata1", loaddata1, r.ld1);
    check("hold_lane_err", {30'b0, lane_err}, {30'b0, r.err});
    check("port_queue_drained", exp_port.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; load_ena = 1'b0; store_ena = 1'b0; wen = '0; eew = '0;
    aluresult0 = '0; aluresult1 = '0; storedata0 = '0; storedata1 = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    tick(); tick();
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_loaddata0", loaddata0, 32'd0);
    check("rst_loaddata1", loaddata1, 32'd0);
    check("rst_lane_err", {30'b0, lane_err}, 32'd0);
    check("rst_ren_wen", {30'b0, dmem_ren, dmem_wen}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_be", {28'b0, dmem_byte_en}, 32'd0);
    nRST = 1'b1;
    tick();

    // two-lane word load, zero wait
    exp_port.push_back('{32'h100, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 0});
    exp_port.push_back('{32'h104, 4'hF, 32'h0, 1'b0, 32'h12345678, 0});
    exp_res.push_back('{32'hDEADBEEF, 32'h12345678, 2'b00});
    run(1'b1, 1'b0, 2'b11, 2'd2, 32'h100, 32'h104, 32'h5A5A5A5A, 32'hA5A5A5A5, 3);

    // lane-1-only byte store with load_ena also high (store wins)
    exp_port.push_back('{32'h200, 4'b1000, 32'hABABABAB, 1'b1, 32'h0, 0});
    exp_res.push_back('{32'h0, 32'h0, 2'b00});
    run(1'b1, 1'b1, 2'b10, 2'd0, 32'h55, 32'h203, 32'h11223344, 32'hCDEF00AB, 2);

    // halfword load with three wait states
    exp_port.push_back('{32'h100, 4'b1100, 32'h0, 1'b0, 32'hCAFE0000, 3});
    exp_res.push_back('{32'h0000CAFE, 32'h0, 2'b00});
    run(1'b1, 1'b0, 2'b01, 2'd1, 32'h102, 32'h0, 32'h0, 32'h0, 5);

    // misaligned lane 0 is skipped, lane 1 read proceeds
    exp_port.push_back('{32'h104, 4'b0011, 32'h0, 1'b0, 32'h5555BEEF, 0});
    exp_res.push_back('{32'h0, 32'h0000BEEF, 2'b01});
    run(1'b1, 1'b0, 2'b11, 2'd1, 32'h101, 32'h104, 32'h0, 32'h0, 3);

    // reserved eew flags the lane without a port access
    exp_res.push_back('{32'h0, 32'h0, 2'b01});
    run(1'b1, 1'b0, 2'b01, 2'd3, 32'h200, 32'h0, 32'h0, 32'h0, 2);

    // byte loads at odd offsets
    exp_port.push_back('{32'h300, 4'b0010, 32'h0, 1'b0, 32'h11223344, 0});
    exp_port.push_back('{32'h300, 4'b0100, 32'h0, 1'b0, 32'hAABBCCDD, 1});
    exp_res.push_back('{32'h00000033, 32'h000000BB, 2'b00});
    run(1'b1, 1'b0, 2'b11, 2'd0, 32'h301, 32'h302, 32'h0, 32'h0, 4);

    // reset while lane 1 waits for ack
    exp_port.push_back('{32'h400, 4'hF, 32'h0, 1'b0, 32'h01020304, 0});
    exp_port.push_back('{32'h408, 4'hF, 32'h0, 1'b0, 32'h0, 20});
    load_ena = 1'b1; wen = 2'b11; eew = 2'd2; aluresult0 = 32'h400; aluresult1 = 32'h408;
    tick();
    load_ena = 1'b0;
    for (int i = 0; i < 10 && dmem_addr !== 32'h408; i++) tick();
    check("reach_lane1", dmem_addr, 32'h408);
    tick(); tick();
    check("lane1_captured_ld0", loaddata0, 32'h01020304);
    #2;
    nRST = 1'b0;
    #1;
    check("rst_mid_stall", {31'b0, stall}, 32'd0);
    check("rst_mid_ren", {31'b0, dmem_ren}, 32'd0);
    check("rst_mid_addr", dmem_addr, 32'd0);
    check("rst_mid_be", {28'b0, dmem_byte_en}, 32'd0);
    check("rst_mid_loaddata0", loaddata0, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    exp_port.delete();
    tick();
    check("rst_hold_done", {31'b0, done}, 32'd0);
    nRST = 1'b1;
    tick();
    check("post_rst_done", {31'b0, done}, 32'd0);
    exp_port.push_back('{32'h10, 4'b1100, 32'h12341234, 1'b1, 32'h0, 0});
    exp_res.push_back('{32'h0, 32'h0, 2'b00});
    run(1'b0, 1'b1, 2'b01, 2'd1, 32'h12, 32'h0, 32'h99991234, 32'h0, 2);

    // empty lane mask is never accepted
    load_ena = 1'b1; wen = 2'b00; eew = 2'd2; aluresult0 = 32'h500;
    #1;
    check("wen0_stall", {31'b0, stall}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wen0_no_done", {31'b0, done}, 32'd0);
      check("wen0_no_ren", {31'b0, dmem_ren}, 32'd0);
      check("wen0_no_stall", {31'b0, stall}, 32'd0);
    end
    load_ena = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
